imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Sequential loader directly upstream of instruction memory; drives its write port (enable/address/data_in).
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words to consecutive instruction-memory addresses starting at 0.
- Asserts cpu_hold so the single-cycle core stalls while the program is loaded.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2**ADDR_W.
- DATA_W, 32, instruction word width; fixed at 4 bytes.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load when idle.
- byte_valid  input  1  source has a byte on byte_data.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts byte_data this cycle.
- imem_enable  output  1  instruction-memory write strobe.
- imem_address  output  ADDR_W  instruction-memory word address.
- imem_data_in  output  DATA_W  word to write.
- cpu_hold  output  1  core stall request.
- busy  output  1  a load is in progress.
- done  output  1  one-cycle pulse when the load completes.
- error  output  1  checksum mismatch, sticky until the next start.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE. All outputs 0, including address, data, word/byte counters and the assembly register.
- All outputs are registered.
- Byte transfer occurs on a cycle with byte_valid && byte_ready. byte_valid without ready: the byte is held by the source and not consumed.
- IDLE: byte_ready=0, cpu_hold=0. On start: go to LEN, set busy=1 and cpu_hold=1, clear error.
- LEN: byte_ready=1. The accepted byte is the word count N; N=0 means 2**ADDR_W words. Go to LOAD with byte_idx=0 and word_idx=0.
- LOAD: byte_ready=1.
  - Accepted byte goes to lane byte_idx: lane 0 = bits 7:0, lane 3 = bits 31:24.
  - byte_idx wraps 3→0.
  - On lane 3: latch the full word into imem_data_in, put word_idx on imem_address, go to WRITE.
- WRITE: exactly one cycle. imem_enable=1, byte_ready=0, address and data stable.
  - If word_idx==N-1 (mod 2**ADDR_W): go to CHK if the checksum macro is defined, else FIN.
  - Otherwise: word_idx+1, back to LOAD.
- FIN: one cycle. done=1, busy=0, cpu_hold=0. Then IDLE.
- Back-to-back bytes at full rate: one word per 5 cycles (4 accept + 1 write).
- start while not IDLE is ignored.
- Reset mid-load aborts immediately. Words already written stay in memory and the partial word is discarded.
- imem_enable is never asserted outside WRITE.
- Address increments wrap modulo 2**ADDR_W.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of the count byte and every data byte accepted since start.
  - After the last WRITE, go to CHK (byte_ready=1). Accept one checksum byte; error=1 if it differs from the running XOR.
  - Then FIN; done pulses either way.
- Undefined: no CHK state, no checksum byte expected, error tied 0.

Decomposition:
- Package imem_loader_pkg:
  - State encoding enum: IDLE, LEN, LOAD, WRITE, CHK, FIN.
  - BYTES_PER_WORD=4 and the byte-lane index width.
- Natural sub-module: word_assembler. It does byte-lane shifting/latching and byte_idx counting, with a word_complete strobe.
- The FSM, counters and checksum stay in the top.

Test Plan:
- Reset mid-LOAD after 6 bytes → all outputs 0, state IDLE, no further imem_enable.
- start, N=2, bytes 13 00 00 00 93 00 10 00 → writes addr0=0x00000013, addr1=0x00100093. Exactly two 1-cycle imem_enable pulses; done pulses once; cpu_hold falls with done.
- byte_valid toggling every other cycle with N=1 → same word written; no byte lost or duplicated; byte_ready=0 during the WRITE cycle.
- N=0 with 1024 data bytes → 256 writes, addresses 0..255, address wraps to 0 internally, then done.
- start asserted during LOAD → ignored; word_idx and byte_idx unchanged.
- Checksum macro defined:
  - N=1 with data 13 00 00 00, checksum byte 0x12 (0x01^0x13) → error=0.
  - Same load with checksum 0x00 → error=1, held until the next start.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and word-lane constants shared by the loader and its word assembler.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = BYTES_PER_WORD * 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    WRITE,
    CHK,
    FIN
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// imem_loader_word_assembler: packs accepted bytes little-endian into a word and flags the lane-3 byte.
// o_word is only meaningful in the cycle o_word_complete is high (top lane comes straight from i_byte).
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [7:0]        i_byte,
  output logic              o_word_complete,
  output logic [WORD_W-1:0] o_word
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] r_byte_idx;
  logic [WORD_W-9:0] r_lanes;

  assign o_word_complete = i_accept && (r_byte_idx == LAST_LANE);
  assign o_word          = {i_byte, r_lanes};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_idx <= '0;
      r_lanes    <= '0;
    end else if (i_clear) begin
      r_byte_idx <= '0;
      r_lanes    <= '0;
    end else if (i_accept) begin
      r_byte_idx <= r_byte_idx + LANE_W'(1);
      case (r_byte_idx)
        2'd0:    r_lanes[7:0]   <= i_byte;
        2'd1:    r_lanes[15:8]  <= i_byte;
        2'd2:    r_lanes[23:16] <= i_byte;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a byte-serial program into instruction memory while stalling the core.
// Define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte and drive error.
//
// state | meaning
// IDLE  | waiting for start, core runs
// LEN   | accept word-count byte (0 = full memory depth)
// LOAD  | accept data bytes into lanes 0..3
// WRITE | single-cycle instruction-memory write strobe
// CHK   | accept checksum byte (checksum builds only)
// FIN   | single-cycle done pulse, hold released
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_enable,
  output logic [ADDR_W-1:0] imem_address,
  output logic [DATA_W-1:0] imem_data_in,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t r_state;
  state_t w_next;

  logic              r_byte_ready;
  logic              r_imem_enable;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_imem_address;
  logic [DATA_W-1:0] r_imem_data_in;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_word_idx;

  logic              w_accept;
  logic              w_load_accept;
  logic              w_word_complete;
  logic [DATA_W-1:0] w_word;
  logic [ADDR_W-1:0] w_last_idx;
  logic              w_last_word;

  assign w_accept      = byte_valid && r_byte_ready;
  assign w_load_accept = w_accept && (r_state == LOAD);
  // N = 0 wraps to all-ones, which is exactly the full-depth load.
  assign w_last_idx    = r_count - ADDR_W'(1);
  assign w_last_word   = (r_word_idx == w_last_idx);

  imem_loader_word_assembler u_word_assembler (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (r_state == LEN),
    .i_accept        (w_load_accept),
    .i_byte          (byte_data),
    .o_word_complete (w_word_complete),
    .o_word          (w_word)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = LEN;
      LEN:   if (w_accept) w_next = LOAD;
      LOAD:  if (w_word_complete) w_next = WRITE;
      WRITE: begin
        if (!w_last_word) begin
          w_next = LOAD;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = CHK;
`else
          w_next = FIN;
`endif
        end
      end
      CHK:     if (w_accept) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered yet line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_byte_ready   <= 1'b0;
      r_imem_enable  <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_imem_address <= '0;
      r_imem_data_in <= '0;
      r_count        <= '0;
      r_word_idx     <= '0;
    end else begin
      r_state       <= w_next;
      r_byte_ready  <= (w_next == LEN) || (w_next == LOAD) || (w_next == CHK);
      r_imem_enable <= (w_next == WRITE);
      r_busy        <= (w_next == LEN) || (w_next == LOAD) || (w_next == WRITE) || (w_next == CHK);
      r_done        <= (w_next == FIN);
      if ((r_state == LEN) && w_accept) begin
        r_count    <= ADDR_W'(byte_data);
        r_word_idx <= '0;
      end else if ((r_state == WRITE) && !w_last_word) begin
        r_word_idx <= r_word_idx + ADDR_W'(1);
      end
      if (w_word_complete) begin
        r_imem_address <= r_word_idx;
        r_imem_data_in <= w_word;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_error;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum  <= '0;
      r_error <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_csum  <= '0;
      r_error <= 1'b0;
    end else if ((r_state == LEN) && w_accept) begin
      r_csum <= byte_data;
    end else if (w_load_accept) begin
      r_csum <= r_csum ^ byte_data;
    end else if ((r_state == CHK) && w_accept) begin
      r_error <= (byte_data != r_csum);
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign byte_ready   = r_byte_ready;
  assign imem_enable  = r_imem_enable;
  assign imem_address = r_imem_address;
  assign imem_data_in = r_imem_data_in;
  assign cpu_hold     = r_busy;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenarios for imem_loader with a negedge write/done monitor.
// Define IMEM_LOADER_CHECKSUM_EN for both RTL and bench to exercise the checksum byte.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              imem_enable;
  logic [ADDR_W-1:0] imem_address;
  logic [DATA_W-1:0] imem_data_in;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;
  int n_double = 0;
  int n_bad_ready = 0;
  int n_stall = 0;
  logic prev_en = 1'b0;
  logic [7:0] tb_csum = 8'h00;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int                wr_cyc[$];

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_enable  (imem_enable),
    .imem_address (imem_address),
    .imem_data_in (imem_data_in),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Plays the role of the instruction memory: logs every write strobe.
  always @(negedge clk) begin
    cyc++;
    if (done) n_done++;
    if (imem_enable) begin
      wr_addr.push_back(imem_address);
      wr_data.push_back(imem_data_in);
      wr_cyc.push_back(cyc);
      if (prev_en) n_double++;
      if (byte_ready) n_bad_ready++;
    end
    prev_en = imem_enable;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    #1;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    n_done = 0;
    n_double = 0;
    n_bad_ready = 0;
    n_stall = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    tb_csum = 8'h00;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_stall++;
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
      tb_csum = tb_csum ^ b;
`endif
    end
  endtask

  task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = tb_csum;
    send_byte(c);
`endif
  endtask

  task automatic end_bytes();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(output int waited);
    waited = 0;
    while (!done && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({byte_ready, imem_enable, imem_address, imem_data_in, cpu_hold, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: outputs=%h, required all 0",
               {byte_ready, imem_enable, imem_address, imem_data_in, cpu_hold, busy, done, error});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({byte_ready, imem_enable, imem_address, imem_data_in, cpu_hold, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%h, required all 0",
               {byte_ready, imem_enable, imem_address, imem_data_in, cpu_hold, busy, done, error});
    end
  endtask

  task automatic test_two_words();
    int w;
    clear_log();
    pulse_start();
    n_tests++;
    if ({busy, cpu_hold, byte_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL two_start: busy,hold,ready=%b, required 111", {busy, cpu_hold, byte_ready});
    end
    send_byte(8'h02);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    finish_load();
    end_bytes();
    wait_done(w);
    n_tests++;
    if (w >= 3000) begin
      n_fail++;
      $display("FAIL two_done_timeout: waited %0d cycles, required done", w);
    end
    n_tests++;
    if ({cpu_hold, busy, error} !== 3'b000) begin
      n_fail++;
      $display("FAIL two_hold_at_done: hold,busy,error=%b, required 000", {cpu_hold, busy, error});
    end
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (n_stall !== 0) begin
      n_fail++;
      $display("FAIL two_stall: %0d stalled bytes, required 0", n_stall);
    end
    n_tests++;
    if (wr_addr.size() !== 2) begin
      n_fail++;
      $display("FAIL two_write_count: %0d writes, required 2", wr_addr.size());
    end
    n_tests++;
    if (wr_addr.size() < 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00000013) begin
      n_fail++;
      $display("FAIL two_word0: addr=%h data=%h, required 00 00000013", wr_addr[0], wr_data[0]);
    end
    n_tests++;
    if (wr_addr.size() < 2 || wr_addr[1] !== 8'h01 || wr_data[1] !== 32'h00100093) begin
      n_fail++;
      $display("FAIL two_word1: addr=%h data=%h, required 01 00100093", wr_addr[1], wr_data[1]);
    end
    n_tests++;
    if (wr_cyc.size() < 2 || (wr_cyc[1] - wr_cyc[0]) !== 5) begin
      n_fail++;
      $display("FAIL two_rate: write spacing %0d cycles, required 5", wr_cyc[1] - wr_cyc[0]);
    end
    n_tests++;
    if (n_double !== 0 || n_done !== 1) begin
      n_fail++;
      $display("FAIL two_pulses: multi-cycle enables=%0d done pulses=%0d, required 0 and 1", n_double, n_done);
    end
  endtask

  task automatic test_gap();
    int w;
    logic [7:0] bytes_in [4];
    bytes_in = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    pulse_start();
    send_byte(8'h01);
    @(negedge clk);
    byte_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes_in[i]);
      @(negedge clk);
      byte_valid = 1'b0;
    end
    finish_load();
    end_bytes();
    wait_done(w);
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (w >= 3000 || n_stall !== 0) begin
      n_fail++;
      $display("FAIL gap_progress: waited %0d stalls %0d, required done and 0 stalls", w, n_stall);
    end
    n_tests++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h44332211) begin
      n_fail++;
      $display("FAIL gap_word: %0d writes addr=%h data=%h, required 1 write 00 44332211",
               wr_addr.size(), wr_addr[0], wr_data[0]);
    end
    n_tests++;
    if (n_bad_ready !== 0) begin
      n_fail++;
      $display("FAIL gap_ready_in_write: byte_ready high in %0d write cycles, required 0", n_bad_ready);
    end
  endtask

  task automatic test_start_ignored();
    int w;
    clear_log();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'hD4); send_byte(8'hC3);
    end_bytes();
    pulse_start();
    n_tests++;
    if ({busy, cpu_hold} !== 2'b11) begin
      n_fail++;
      $display("FAIL ign_busy: busy,hold=%b, required 11", {busy, cpu_hold});
    end
    send_byte(8'hB2); send_byte(8'hA1);
    send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
`ifdef IMEM_LOADER_CHECKSUM_EN
    tb_csum = 8'h02 ^ 8'hD4 ^ 8'hC3 ^ 8'hB2 ^ 8'hA1 ^ 8'h04 ^ 8'h03 ^ 8'h02 ^ 8'h01;
`endif
    finish_load();
    end_bytes();
    wait_done(w);
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (w >= 3000 || n_stall !== 0) begin
      n_fail++;
      $display("FAIL ign_progress: waited %0d stalls %0d, required done and 0 stalls", w, n_stall);
    end
    n_tests++;
    if (wr_addr.size() !== 2 || wr_data[0] !== 32'hA1B2C3D4 || wr_data[1] !== 32'h01020304
        || wr_addr[1] !== 8'h01) begin
      n_fail++;
      $display("FAIL ign_words: %0d writes d0=%h d1=%h a1=%h, required 2 A1B2C3D4 01020304 01",
               wr_addr.size(), wr_data[0], wr_data[1], wr_addr[1]);
    end
  endtask

  task automatic test_full_depth();
    int w;
    int n_bad;
    logic [7:0] kb;
    clear_log();
    pulse_start();
    send_byte(8'h00);
    for (int k = 0; k < 256; k++) begin
      kb = 8'(k);
      send_byte(kb); send_byte(8'h5A); send_byte(~kb); send_byte(kb);
    end
    finish_load();
    end_bytes();
    wait_done(w);
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (w >= 3000 || n_stall !== 0) begin
      n_fail++;
      $display("FAIL full_progress: waited %0d stalls %0d, required done and 0 stalls", w, n_stall);
    end
    n_tests++;
    if (wr_addr.size() !== 256) begin
      n_fail++;
      $display("FAIL full_count: %0d writes, required 256", wr_addr.size());
    end
    n_bad = 0;
    for (int k = 0; k < wr_addr.size(); k++) begin
      kb = 8'(k);
      if (wr_addr[k] !== ADDR_W'(k) || wr_data[k] !== {kb, ~kb, 8'h5A, kb}) n_bad++;
    end
    n_tests++;
    if (n_bad !== 0) begin
      n_fail++;
      $display("FAIL full_contents: %0d wrong address/data entries, required 0", n_bad);
    end
    n_tests++;
    if (n_done !== 1 || n_double !== 0) begin
      n_fail++;
      $display("FAIL full_pulses: done pulses=%0d multi-cycle enables=%0d, required 1 and 0", n_done, n_double);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    pulse_start();
    send_byte(8'h04);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'hEE); send_byte(8'hFF);
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({byte_ready, imem_enable, imem_address, imem_data_in, cpu_hold, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: outputs=%h, required all 0",
               {byte_ready, imem_enable, imem_address, imem_data_in, cpu_hold, busy, done, error});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h55;
    repeat (10) @(negedge clk);
    #1;
    n_tests++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hDDCCBBAA) begin
      n_fail++;
      $display("FAIL midrst_writes: %0d writes d0=%h, required 1 write DDCCBBAA", wr_addr.size(), wr_data[0]);
    end
    n_tests++;
    if ({busy, cpu_hold, byte_ready, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_idle: busy,hold,ready,done=%b, required 0000", {busy, cpu_hold, byte_ready, done});
    end
    byte_valid = 1'b0;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_ok();
    int w;
    clear_log();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h12);
    end_bytes();
    wait_done(w);
    n_tests++;
    if (w >= 3000 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_ok: waited %0d error=%b, required done with error 0", w, error);
    end
  endtask

  task automatic test_checksum_bad();
    int w;
    clear_log();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00);
    end_bytes();
    wait_done(w);
    n_tests++;
    if (w >= 3000 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL csum_bad: waited %0d error=%b, required done with error 1", w, error);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL csum_sticky: error=%b, required 1", error);
    end
    pulse_start();
    n_tests++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_clear_on_start: error=%b, required 0", error);
    end
    send_byte(8'h01);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    finish_load();
    end_bytes();
    wait_done(w);
    n_tests++;
    if (w >= 3000 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_reload: waited %0d error=%b, required done with error 0", w, error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_gap();
    test_start_ignored();
    test_full_depth();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_ok();
    test_checksum_bad();
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
